// File: rtl/snn_reward_readout.sv
// -----------------------------------------------------------------------------
// snn_reward_readout
//   Readout stage behind the spiking network core. This block collects WINDOW
//   valid output samples and computes their truncated average. It also counts
//   the spikes, which are samples strictly above SPIKE_TH. The average is then
//   compared with a latched target level. The result is a signed reward
//   (+1/0/-1): it reflects whether the error shrank or grew against the last
//   *accepted* result. A hit flag is also produced. Results are offered
//   through a valid/ready handshake.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   ena       in   advance enable; when low every register holds
//   start     in   begin a window (target latched on acceptance)
//   target    in   [7:0] desired average level
//   in_valid  in   net_out carries a sample this cycle
//   net_out   in   [7:0] core output sample
//   rw_valid  out  result available
//   rw_ready  in   consumer accepts the result
//   reward    out  [1:0] two's complement +1 / 0 / -1
//   avg_out   out  [7:0] window average
//   err_out   out  [7:0] |avg - target|
//   spike_cnt out  [8:0] spikes in the window (0..256)
//   hit       out  err_out <= TOL
//   busy      out  FSM not idle
// -----------------------------------------------------------------------------
module snn_reward_readout #(
  parameter int          WINDOW   = 16,
  parameter logic [7:0]  SPIKE_TH = 8'h01,
  parameter int          TOL      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic [7:0] target,
  input  logic       in_valid,
  input  logic [7:0] net_out,
  output logic       rw_valid,
  input  logic       rw_ready,
  output logic [1:0] reward,
  output logic [7:0] avg_out,
  output logic [7:0] err_out,
  output logic [8:0] spike_cnt,
  output logic       hit,
  output logic       busy
);

  localparam int LW = $clog2(WINDOW);
  localparam int AW = 8 + LW;   // WINDOW samples of 8 bits cannot overflow
  localparam int CW = LW + 1;   // must be able to hold WINDOW itself
  localparam logic [CW-1:0] WIN_C = CW'(WINDOW);
  localparam logic [7:0]    TOL_C = 8'(TOL);

  typedef enum logic [1:0] {IDLE, ACCUM, EVAL, HOLD} state_t;

  state_t          state_q, state_d;
  logic [7:0]      target_q, target_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [8:0]      spk_acc_q, spk_acc_d;     // running count; copied out at EVAL
  logic [7:0]      prev_err_q, prev_err_d;
  logic            rw_valid_q, rw_valid_d;
  logic [1:0]      reward_q, reward_d;
  logic [7:0]      avg_q, avg_d;
  logic [7:0]      err_q, err_d;
  logic [8:0]      spike_q, spike_d;
  logic            hit_q, hit_d;

  // Evaluation datapath, only consumed in EVAL.
  logic [7:0] avg_w;
  logic [7:0] err_w;
  assign avg_w = acc_q[AW-1:LW];
  assign err_w = (avg_w >= target_q) ? (avg_w - target_q) : (target_q - avg_w);

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    acc_d        = acc_q;
    sample_cnt_d = sample_cnt_q;
    spk_acc_d    = spk_acc_q;
    prev_err_d   = prev_err_q;
    rw_valid_d   = rw_valid_q;
    reward_d     = reward_q;
    avg_d        = avg_q;
    err_d        = err_q;
    spike_d      = spike_q;
    hit_d        = hit_q;

    if (ena) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d      = ACCUM;
            target_d     = target;
            acc_d        = '0;
            sample_cnt_d = '0;
            spk_acc_d    = '0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_d        = acc_q + {{LW{1'b0}}, net_out};
            sample_cnt_d = sample_cnt_q + 1'b1;
            spk_acc_d    = spk_acc_q + {8'b0, (net_out > SPIKE_TH)};
            if (sample_cnt_q + 1'b1 == WIN_C) state_d = EVAL;
          end
        end
        EVAL: begin
          avg_d      = avg_w;
          err_d      = err_w;
          spike_d    = spk_acc_q;
          hit_d      = (err_w <= TOL_C);
          if (err_w < prev_err_q)      reward_d = 2'b01;
          else if (err_w > prev_err_q) reward_d = 2'b11;
          else                         reward_d = 2'b00;
          rw_valid_d = 1'b1;
          state_d    = HOLD;
        end
        HOLD: begin
          if (rw_ready) begin
            rw_valid_d = 1'b0;
            prev_err_d = err_q;
            // A start coinciding with the handshake opens the next window
            // immediately so back-to-back windows lose no cycle.
            if (start) begin
              state_d      = ACCUM;
              target_d     = target;
              acc_d        = '0;
              sample_cnt_d = '0;
              spk_acc_d    = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      target_q     <= '0;
      acc_q        <= '0;
      sample_cnt_q <= '0;
      spk_acc_q    <= '0;
      prev_err_q   <= 8'hFF;   // first window after reset rewards any err < FF
      rw_valid_q   <= 1'b0;
      reward_q     <= '0;
      avg_q        <= '0;
      err_q        <= '0;
      spike_q      <= '0;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      acc_q        <= acc_d;
      sample_cnt_q <= sample_cnt_d;
      spk_acc_q    <= spk_acc_d;
      prev_err_q   <= prev_err_d;
      rw_valid_q   <= rw_valid_d;
      reward_q     <= reward_d;
      avg_q        <= avg_d;
      err_q        <= err_d;
      spike_q      <= spike_d;
      hit_q        <= hit_d;
    end
  end

  assign rw_valid  = rw_valid_q;
  assign reward    = reward_q;
  assign avg_out   = avg_q;
  assign err_out   = err_q;
  assign spike_cnt = spike_q;
  assign hit       = hit_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_snn_reward_readout.sv
module tb_snn_reward_readout;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic [7:0] target = 8'h00;
  logic       in_valid = 1'b0;
  logic [7:0] net_out = 8'h00;
  logic       rw_valid;
  logic       rw_ready = 1'b1;
  logic [1:0] reward;
  logic [7:0] avg_out;
  logic [7:0] err_out;
  logic [8:0] spike_cnt;
  logic       hit;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  snn_reward_readout dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .target    (target),
    .in_valid  (in_valid),
    .net_out   (net_out),
    .rw_valid  (rw_valid),
    .rw_ready  (rw_ready),
    .reward    (reward),
    .avg_out   (avg_out),
    .err_out   (err_out),
    .spike_cnt (spike_cnt),
    .hit       (hit),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_win(input logic [7:0] t);
    start  = 1'b1;
    target = t;
    step();
    start  = 1'b0;
    target = 8'hAA;   // later target changes must not matter
  endtask

  task automatic feed(input logic [7:0] v);
    in_valid = 1'b1;
    net_out  = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic feed_n(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) feed(v);
  endtask

  // Called in the EVAL cycle: next edge must present the result.
  task automatic expect_result(input string tag, input logic [7:0] e_avg,
                               input logic [7:0] e_err, input logic [1:0] e_rw,
                               input logic e_hit, input logic [8:0] e_spk);
    check({tag, "_pre_valid"}, rw_valid, 0);
    step();
    check({tag, "_valid"},  rw_valid, 1);
    check({tag, "_avg"},    avg_out, e_avg);
    check({tag, "_err"},    err_out, e_err);
    check({tag, "_reward"}, reward, e_rw);
    check({tag, "_hit"},    hit, e_hit);
    check({tag, "_spikes"}, spike_cnt, e_spk);
    check({tag, "_busy"},   busy, 1);
    $display("window %s: avg=%h err=%h reward=%b hit=%b spikes=%0d",
             tag, avg_out, err_out, reward, hit, spike_cnt);
  endtask

  // rw_ready already high: handshake edge returns to IDLE.
  task automatic handshake_idle(input string tag);
    step();
    check({tag, "_valid_drop"}, rw_valid, 0);
    check({tag, "_idle"},       busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rst_valid"},  rw_valid, 0);
    check({tag, "_rst_reward"}, reward, 0);
    check({tag, "_rst_avg"},    avg_out, 0);
    check({tag, "_rst_err"},    err_out, 0);
    check({tag, "_rst_spikes"}, spike_cnt, 0);
    check({tag, "_rst_hit"},    hit, 0);
    check({tag, "_rst_busy"},   busy, 0);
  endtask

  initial begin
    logic [7:0] s_avg, s_err;
    logic [1:0] s_rw;
    int acc_n, guard;
    bit paused;

    #12;
    check_reset_outputs("por");
    rst_n = 1'b1;
    step();

    // Case 1: exact target, first window -> +1 because prev_err is FF.
    start_win(8'h20);
    feed_n(8'h20, 16);
    expect_result("c1", 8'h20, 8'h00, 2'b01, 1'b1, 9'd16);
    handshake_idle("c1");

    // Case 2: follow-on windows.
    start_win(8'h20);
    feed_n(8'h10, 16);
    expect_result("c2a", 8'h10, 8'h10, 2'b11, 1'b0, 9'd16);
    handshake_idle("c2a");
    start_win(8'h20);
    feed_n(8'h10, 16);
    expect_result("c2b", 8'h10, 8'h10, 2'b00, 1'b0, 9'd16);
    handshake_idle("c2b");
    start_win(8'h20);
    feed_n(8'h1E, 16);
    expect_result("c2c", 8'h1E, 8'h02, 2'b01, 1'b1, 9'd16);
    handshake_idle("c2c");

    // Case 3: random in_valid gaps, ena low 3 cycles mid-window.
    start_win(8'h20);
    acc_n = 0; guard = 0; paused = 0;
    while (acc_n < 16 && guard < 400) begin
      if (!paused && acc_n == 8) begin
        ena = 1'b0; in_valid = 1'b1; net_out = 8'hFF;   // must not be accepted
        repeat (3) begin
          step();
          check("c3_pause_busy", busy, 1);
        end
        ena = 1'b1; paused = 1;
      end
      in_valid = 1'($urandom_range(0, 1));
      net_out  = 8'h20;
      check("c3_no_early_valid", rw_valid, 0);
      step();
      if (in_valid) acc_n++;
      guard++;
    end
    in_valid = 1'b0;
    check("c3_sample_budget", acc_n, 16);
    ena = 1'b0;
    step(); step();
    check("c3_hold_disabled", rw_valid, 0);
    ena = 1'b1;
    expect_result("c3", 8'h20, 8'h00, 2'b01, 1'b1, 9'd16);
    handshake_idle("c3");

    // Case 4: backpressure, then back-to-back start on the handshake.
    rw_ready = 1'b0;
    start_win(8'h20);
    feed_n(8'h20, 16);
    expect_result("c4", 8'h20, 8'h00, 2'b00, 1'b1, 9'd16);
    s_avg = avg_out; s_err = err_out; s_rw = reward;
    for (int i = 0; i < 5; i++) begin
      start  = i[0];
      target = 8'h55;
      step();
      check("c4_stall_valid",  rw_valid, 1);
      check("c4_stall_avg",    avg_out, s_avg);
      check("c4_stall_err",    err_out, s_err);
      check("c4_stall_reward", reward, s_rw);
      check("c4_stall_busy",   busy, 1);
    end
    rw_ready = 1'b1;
    start    = 1'b1;
    target   = 8'h10;
    step();
    start    = 1'b0;
    target   = 8'hAA;
    check("c4_b2b_valid_drop", rw_valid, 0);
    check("c4_b2b_busy",       busy, 1);
    feed_n(8'h10, 16);
    expect_result("c4b", 8'h10, 8'h00, 2'b00, 1'b1, 9'd16);
    handshake_idle("c4b");

    // Case 5: spike threshold is strict; err 4 sits exactly on TOL.
    start_win(8'h05);
    for (int i = 0; i < 16; i++) feed(i[0] ? 8'h02 : 8'h01);
    expect_result("c5", 8'h01, 8'h04, 2'b11, 1'b1, 9'd8);
    handshake_idle("c5");

    // Case 6: asynchronous reset mid-window.
    start_win(8'h20);
    feed_n(8'h20, 7);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("c6");
    #1 rst_n = 1'b1;
    step();
    // err 0x10 would give -1 against the pre-reset prev_err of 4.
    start_win(8'h20);
    feed_n(8'h10, 16);
    expect_result("c6a", 8'h10, 8'h10, 2'b01, 1'b0, 9'd16);
    handshake_idle("c6a");
    start_win(8'h20);
    feed_n(8'h20, 16);
    expect_result("c6b", 8'h20, 8'h00, 2'b01, 1'b1, 9'd16);
    handshake_idle("c6b");

    // err = FF right after reset equals prev_err -> reward 0.
    rst_n = 1'b0;
    #3 rst_n = 1'b1;
    step();
    start_win(8'hFF);
    feed_n(8'h00, 16);
    expect_result("c7", 8'h00, 8'hFF, 2'b00, 1'b0, 9'd0);
    handshake_idle("c7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
